// File: rtl/keccak_sponge.sv
// Sponge controller for a serial Keccak-p[200] core: buffers one rate block, pads, absorbs, squeezes.
// Latency: 0..24 align + 25 absorb + core permutation per block; then up to 24 align + 25 squeeze cycles.
// Backpressure: msg_ready_o low while a block awaits absorb; digest output has no backpressure.
module keccak_sponge #(
  parameter int           W          = 8,
  parameter int           RATE_LANES = 18,
  parameter int           OUT_LANES  = 16,
  parameter logic [W-1:0] DOMAIN     = W'(6)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] msg_data_i,
  input  logic         msg_valid_i,
  input  logic         msg_last_i,
  output logic         msg_ready_o,
  output logic [W-1:0] dig_data_o,
  output logic         dig_valid_o,
  output logic         dig_last_o,
  output logic         core_reset_o,
  output logic [W-1:0] core_in_data_o,
  input  logic [W-1:0] core_out_data_i,
  input  logic         core_ready_i
);
  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_FILL    = 3'd1;
  localparam logic [2:0] S_ABSORB  = 3'd2;
  localparam logic [2:0] S_PERM    = 3'd3;
  localparam logic [2:0] S_SQWAIT  = 3'd4;
  localparam logic [2:0] S_SQUEEZE = 3'd5;

  localparam logic [4:0]   LAST_POS = 5'd24;
  localparam logic [4:0]   RATE     = 5'(RATE_LANES);
  localparam logic [4:0]   OUTL     = 5'(OUT_LANES);
  localparam logic [W-1:0] PAD_END  = {1'b1, {(W-1){1'b0}}};

  logic [2:0]   state_q, state_d;
  logic [4:0]   pos_q, pos_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         done_q, done_d;
  logic         pad_pending_q, pad_pending_d;
  logic         final_q, final_d;
  logic [W-1:0] lane_buf_q [RATE_LANES];
  logic [W-1:0] lane_buf_d [RATE_LANES];
  logic         core_reset_q;
  logic [W-1:0] dig_data_q;
  logic         dig_valid_q, dig_last_q;
  logic         accept;
  logic [4:0]   k;
  logic [W-1:0] absorb_term;

  assign msg_ready_o  = (state_q == S_FILL) && !done_q && !pad_pending_q;
  assign accept       = msg_ready_o & msg_valid_i;
  assign k            = cnt_q + 5'd1;
  assign core_reset_o = core_reset_q;
  assign dig_data_o   = dig_data_q;
  assign dig_valid_o  = dig_valid_q;
  assign dig_last_o   = dig_last_q;

  // Next state: lane position tracking, block buffering with padding, and phase sequencing.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_d        = done_q;
    pad_pending_d = pad_pending_q;
    final_d       = final_q;
    lane_buf_d    = lane_buf_q;
    // In PERM the core is not shifting; the CoreReady cycle shifts lane 0 out, so pos resumes at 1.
    if (state_q == S_PERM) pos_d = core_ready_i ? 5'd1 : 5'd0;
    else                   pos_d = (pos_q == LAST_POS) ? 5'd0 : pos_q + 5'd1;
    case (state_q)
      S_INIT: if (pos_q == LAST_POS) state_d = S_FILL;
      S_FILL: begin
        if (pad_pending_q && !done_q) begin
          // Message ended exactly on a block boundary: this block is padding only.
          lane_buf_d[0]            = DOMAIN;
          lane_buf_d[RATE_LANES-1] = lane_buf_d[RATE_LANES-1] ^ PAD_END;
          done_d        = 1'b1;
          final_d       = 1'b1;
          pad_pending_d = 1'b0;
        end else if (accept) begin
          cnt_d = k;
          for (int i = 0; i < RATE_LANES; i++)
            if (5'(i) == cnt_q) lane_buf_d[i] = msg_data_i;
          if (k == RATE) done_d = 1'b1;
          if (msg_last_i) begin
            done_d = 1'b1;
            if (k == RATE) begin
              pad_pending_d = 1'b1;
            end else begin
              final_d = 1'b1;
              for (int i = 0; i < RATE_LANES; i++)
                if (5'(i) == k) lane_buf_d[i] = DOMAIN;
              lane_buf_d[RATE_LANES-1] = lane_buf_d[RATE_LANES-1] ^ PAD_END;
            end
          end
        end
        if (done_d && pos_q == LAST_POS) state_d = S_ABSORB;
      end
      S_ABSORB:  if (pos_q == LAST_POS) state_d = S_PERM;
      S_PERM:    if (core_ready_i) state_d = final_q ? S_SQWAIT : S_FILL;
      S_SQWAIT:  if (pos_q == LAST_POS) state_d = S_SQUEEZE;
      S_SQUEEZE: if (pos_q == LAST_POS) begin
        state_d = S_FILL;
        final_d = 1'b0;
      end
      default:   state_d = S_INIT;
    endcase
    // Every entry into FILL starts a fresh, zeroed block.
    if (state_d == S_FILL && state_q != S_FILL) begin
      cnt_d  = 5'd0;
      done_d = 1'b0;
      for (int i = 0; i < RATE_LANES; i++) lane_buf_d[i] = '0;
    end
  end

  // Core serial input: zero to clear, XOR a buffered lane while absorbing, else rotate.
  always_comb begin
    absorb_term = '0;
    for (int i = 0; i < RATE_LANES; i++)
      if (5'(i) == pos_q) absorb_term = lane_buf_q[i];
    case (state_q)
      S_INIT, S_SQUEEZE: core_in_data_o = '0;
      S_ABSORB:          core_in_data_o = core_out_data_i ^ absorb_term;
      default:           core_in_data_o = core_out_data_i;
    endcase
  end

  // State registers, registered core reset and registered digest output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_INIT;
      pos_q         <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      pad_pending_q <= 1'b0;
      final_q       <= 1'b0;
      core_reset_q  <= 1'b1;
      dig_data_q    <= '0;
      dig_valid_q   <= 1'b0;
      dig_last_q    <= 1'b0;
      for (int i = 0; i < RATE_LANES; i++) lane_buf_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      pad_pending_q <= pad_pending_d;
      final_q       <= final_d;
      core_reset_q  <= (state_d != S_PERM);
      dig_valid_q   <= (state_q == S_SQUEEZE) && (pos_q < OUTL);
      dig_last_q    <= (state_q == S_SQUEEZE) && (pos_q == OUTL - 5'd1);
      dig_data_q    <= ((state_q == S_SQUEEZE) && (pos_q < OUTL)) ? core_out_data_i : '0;
      for (int i = 0; i < RATE_LANES; i++) lane_buf_q[i] <= lane_buf_d[i];
    end
  end
endmodule

// File: tb/tb_keccak_sponge.sv
// Bench for keccak_sponge: a behavioural serial Keccak-p[200] core plus a pad10*1 sponge reference.
// Each block absorbed is checked by the XOR terms the controller injects; digests against the reference.
// Random message lengths, random valid gaps and permutation latencies; resets injected mid-operation.
module tb_keccak_sponge;
  localparam int R   = 18;
  localparam int OUT = 16;
  localparam logic [7:0] DOM = 8'h06;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] msg_data = '0;
  logic       msg_valid = 1'b0, msg_last = 1'b0;
  logic       msg_ready, dig_valid, dig_last, core_reset, core_ready;
  logic [7:0] dig_data, core_in, core_out;

  int checks = 0;
  int errors = 0;

  logic [7:0]   msg_q[$];
  logic [199:0] exp_blocks[$];
  logic [199:0] core_st;
  logic [199:0] hist;
  int           perm_cnt;
  logic         prev_cr = 1'b1;

  always #5 clk = ~clk;

  keccak_sponge #(.W(8), .RATE_LANES(R), .OUT_LANES(OUT), .DOMAIN(DOM)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .msg_data_i(msg_data), .msg_valid_i(msg_valid), .msg_last_i(msg_last), .msg_ready_o(msg_ready),
    .dig_data_o(dig_data), .dig_valid_o(dig_valid), .dig_last_o(dig_last),
    .core_reset_o(core_reset), .core_in_data_o(core_in),
    .core_out_data_i(core_out), .core_ready_i(core_ready)
  );

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  function automatic logic [199:0] keccak_p(input logic [199:0] s);
    int         rot_t [25] = '{0,1,6,4,3, 4,4,6,7,4, 3,2,3,1,7, 1,5,7,5,0, 2,2,5,0,6};
    logic [7:0] rc_t [18] = '{8'h01,8'h82,8'h8A,8'h00,8'h8B,8'h01,8'h81,8'h09,8'h8A,
                              8'h88,8'h09,8'h0A,8'h8B,8'h8B,8'h89,8'h03,8'h02,8'h80};
    logic [7:0] a [25];
    logic [7:0] b [25];
    logic [7:0] c [5];
    logic [7:0] d [5];
    logic [199:0] r;
    for (int i = 0; i < 25; i++) a[i] = s[8*i +: 8];
    for (int rnd = 0; rnd < 18; rnd++) begin
      for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
      for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rol8(c[(x+1)%5], 1);
      for (int i = 0; i < 25; i++) a[i] = a[i] ^ d[i%5];
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          b[y + 5*((2*x + 3*y) % 5)] = rol8(a[x + 5*y], rot_t[x + 5*y]);
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          a[x + 5*y] = b[x + 5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
      a[0] = a[0] ^ rc_t[rnd];
    end
    for (int i = 0; i < 25; i++) r[8*i +: 8] = a[i];
    return r;
  endfunction

  // Serial core: shifts whenever reset or ready is high; lane 24 takes the input, lane 0 is the output.
  assign core_out = core_st[7:0];
  always @(posedge clk) begin
    if (core_reset) begin
      core_st    <= {core_in, core_st[199:8]};
      core_ready <= 1'b0;
      perm_cnt   <= $urandom_range(1, 12);
    end else if (core_ready) begin
      core_st    <= {core_in, core_st[199:8]};
      core_ready <= 1'b0;
      perm_cnt   <= $urandom_range(1, 12);
    end else if (perm_cnt > 0) begin
      perm_cnt <= perm_cnt - 1;
    end else begin
      core_st    <= keccak_p(core_st);
      core_ready <= 1'b1;
    end
  end

  // Last 25 XOR terms injected into the core; oldest lands in lane 0.
  always @(posedge clk) hist <= {core_in ^ core_out, hist[199:8]};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // At each permutation start, the preceding 25 cycles must have injected exactly the padded block.
  always @(negedge clk) begin
    if (rst_n && prev_cr && !core_reset) begin
      chk("absorb_queue_nonempty", 256'(exp_blocks.size() != 0), 256'd1);
      if (exp_blocks.size() != 0) chk("absorb_xor", hist, exp_blocks.pop_front());
    end
    prev_cr = core_reset;
  end

  task automatic make_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference sponge: pad10*1 over the whole message, absorb block by block, squeeze once.
  task automatic build_ref(output logic [8*OUT-1:0] dig);
    logic [7:0]   p[$];
    logic [199:0] st, blk;
    p = msg_q;
    p.push_back(DOM);
    while (p.size() % R != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] ^ 8'h80;
    st = '0;
    for (int bi = 0; bi < p.size() / R; bi++) begin
      blk = '0;
      for (int i = 0; i < R; i++) blk[8*i +: 8] = p[bi*R + i];
      exp_blocks.push_back(blk);
      st = keccak_p(st ^ blk);
    end
    dig = st[8*OUT-1:0];
  endtask

  task automatic send_msg(input string tag, input int gap_max, output logic [8*OUT-1:0] dig);
    int w;
    logic timed_out;
    timed_out = 1'b0;
    build_ref(dig);
    for (int i = 0; i < msg_q.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      msg_valid = 1'b1;
      msg_data  = msg_q[i];
      msg_last  = (i == msg_q.size() - 1);
      w = 0;
      while (!msg_ready && w < 400) begin @(negedge clk); w++; end
      if (w >= 400) timed_out = 1'b1;
      @(negedge clk);
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      msg_data  = 8'($urandom_range(0, 255));
    end
    chk({tag, "_lane_timeout"}, 256'(timed_out), 256'd0);
  endtask

  task automatic recv_digest(input string tag, input logic [8*OUT-1:0] exp);
    logic [8*OUT-1:0] dig;
    int   got, w;
    logic ready_seen, last_bad, gap_seen;
    dig = '0; got = 0; w = 0;
    ready_seen = msg_ready; last_bad = 1'b0; gap_seen = 1'b0;
    while (got < OUT && w < 600) begin
      @(negedge clk); w++;
      if (msg_ready) ready_seen = 1'b1;
      if (dig_valid) begin
        dig[8*got +: 8] = dig_data;
        if (dig_last !== (got == OUT - 1)) last_bad = 1'b1;
        got++;
      end else if (got > 0) gap_seen = 1'b1;
    end
    chk({tag, "_count"}, 256'(got), 256'(OUT));
    chk({tag, "_digest"}, 256'(dig), 256'(exp));
    chk({tag, "_last_gap_ready"}, {last_bad, gap_seen, ready_seen}, 256'd0);
    @(negedge clk);
    chk({tag, "_end"}, {dig_valid, dig_last}, 256'd0);
  endtask

  // Asserts reset at the current time, checks immediate reset values, then the 25-cycle clear.
  task automatic reset_seq(input string tag);
    rst_n = 1'b0; msg_valid = 1'b0; msg_last = 1'b0;
    exp_blocks.delete();
    #1;
    chk({tag, "_rst_vals"}, {msg_ready, dig_valid, dig_last, dig_data, core_reset, core_in},
        {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c < 25)
        chk({tag, "_init_idle"}, {msg_ready, core_reset, core_in, dig_valid, dig_last, dig_data},
            {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00});
      else
        chk({tag, "_ready_rise"}, 256'(msg_ready), 256'd1);
    end
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8*OUT-1:0] d;
    int w;
    #3;
    reset_seq("por");

    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg("abc", 0, d);
    recv_digest("abc", d);

    make_msg(R);
    send_msg("len18", 2, d);
    recv_digest("len18", d);

    make_msg(R - 1);
    send_msg("len17", 2, d);
    recv_digest("len17", d);

    make_msg(2 * R);
    send_msg("len36", 1, d);
    recv_digest("len36", d);

    make_msg(1);
    send_msg("len1", 0, d);
    recv_digest("len1", d);

    for (int t = 0; t < 6; t++) begin
      make_msg($urandom_range(1, 60));
      send_msg("multi", 3, d);
      recv_digest("multi", d);
    end

    // Abort while the first block is being absorbed.
    make_msg(5);
    send_msg("pre_abs", 0, d);
    repeat (24) @(posedge clk);
    #2;
    reset_seq("abort_abs");
    make_msg(23);
    send_msg("post_abs", 2, d);
    recv_digest("post_abs", d);

    // Abort in the middle of the digest stream.
    make_msg(7);
    send_msg("pre_sq", 1, d);
    w = 0;
    while (!dig_valid && w < 800) begin @(negedge clk); w++; end
    chk("sq_reach", 256'(dig_valid), 256'd1);
    repeat (3) @(negedge clk);
    #1;
    reset_seq("abort_sq");
    make_msg(40);
    send_msg("post_sq", 2, d);
    recv_digest("post_sq", d);

    repeat (60) @(negedge clk);
    chk("blocks_left", 256'(exp_blocks.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
